// File: rtl/real_gain_pkg.sv
// Shared definitions for the real-valued gain stage: gain quantisation helper and S1 stage record.
package real_gain_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_GAIN_W = 16;
  localparam int PROD_W     = DEF_DATA_W + DEF_GAIN_W;

  typedef struct packed {
    logic                     valid;
    logic signed [PROD_W-1:0] product;
  } s1_stage_t;

  // Scale by 2**frac_w and round half away from zero; the caller range-checks the result.
  function automatic longint gain_to_fixed(real g, int frac_w);
    real s;
    real r;
    s = g;
    for (int i = 0; i < frac_w; i++) s = s * 2.0;
    if (s >= 0.0) r = $floor(s + 0.5);
    else           r = -$floor(-s + 0.5);
    return longint'(r);
  endfunction

endpackage

// File: rtl/real_gain_sat.sv
// Round-half-up, shift and saturate (REAL_GAIN_SAT_EN defined) or wrap (undefined) of a full product.
module real_gain_sat
  import real_gain_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int P_W    = 32
) (
  input  logic signed [P_W-1:0]    product,
  output logic signed [DATA_W-1:0] result,
  output logic                     out_of_range
);

  // One guard bit so the rounding constant can never overflow the sum.
  localparam int R_W = P_W + 1;

  logic signed [R_W-1:0] rounded;

  function automatic logic signed [R_W-1:0] round_shift(input logic signed [P_W-1:0] p);
    logic signed [R_W-1:0] s;
    s = R_W'(p) + (R_W'(1) <<< (FRAC_W - 1));
    return s >>> FRAC_W;
  endfunction

  function automatic logic range_err(input logic signed [R_W-1:0] r);
    logic [R_W-DATA_W:0] hi;
    hi = r[R_W-1:DATA_W-1];
    return !((&hi) || (~|hi));
  endfunction

  function automatic logic signed [DATA_W-1:0] saturate(input logic signed [R_W-1:0] r);
    if (!range_err(r))  return r[DATA_W-1:0];
    else if (r[R_W-1])  return {1'b1, {(DATA_W-1){1'b0}}};
    else                return {1'b0, {(DATA_W-1){1'b1}}};
  endfunction

  always_comb begin
    rounded      = round_shift(product);
    out_of_range = range_err(rounded);
`ifdef REAL_GAIN_SAT_EN
    result       = saturate(rounded);
`else
    result       = rounded[DATA_W-1:0];
`endif
  end

endmodule

// File: rtl/real_gain_pipe.sv
// Two-stage valid/ready gain stage with elaboration-time quantised real GAIN.
// Optional build macro REAL_GAIN_SAT_EN selects saturation instead of wrap in real_gain_sat.
module real_gain_pipe
  import real_gain_pkg::*;
#(
  parameter real GAIN   = 2.0,
  parameter int  DATA_W = 16,
  parameter int  GAIN_W = 16,
  parameter int  FRAC_W = 8,
  parameter int  CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     ovf,
  output logic [CNT_W-1:0]         count
);

  localparam int     P_W     = DATA_W + GAIN_W;
  localparam longint GQ_FULL = gain_to_fixed(GAIN, FRAC_W);
  localparam longint GQ_MAX  = (64'sd1 <<< (GAIN_W - 1)) - 64'sd1;
  localparam longint GQ_MIN  = -(64'sd1 <<< (GAIN_W - 1));
  localparam logic signed [GAIN_W-1:0] GQ = GAIN_W'(GQ_FULL);

  if (GQ_FULL > GQ_MAX || GQ_FULL < GQ_MIN) begin : g_gain_range
    $error("real_gain_pipe: quantised GAIN %0d does not fit in %0d signed bits", GQ_FULL, GAIN_W);
  end

  typedef struct packed {
    logic                  valid;
    logic signed [P_W-1:0] product;
  } s1_t;

  s1_t                     s1_p1;
  logic                    vld_p2;
  logic signed [DATA_W-1:0] data_p2;
  logic signed [P_W-1:0]   product_p0;
  logic signed [DATA_W-1:0] sat_res;
  logic                    sat_oor;
  logic                    adv;

  assign adv        = !vld_p2 || out_ready;
  assign in_ready   = adv;
  assign out_valid  = vld_p2;
  assign out_data   = data_p2;
  assign product_p0 = P_W'(in_data) * P_W'(GQ);

  real_gain_sat #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W),
    .P_W    (P_W)
  ) u_sat (
    .product      (s1_p1.product),
    .result       (sat_res),
    .out_of_range (sat_oor)
  );

  // S1 captures the product, S2 the rounded result; both move only when the output can advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_p1.valid <= 1'b0;
      vld_p2      <= 1'b0;
      data_p2     <= '0;
      ovf         <= 1'b0;
      count       <= '0;
    end else begin
      if (adv) begin
        s1_p1.valid   <= in_valid;
        s1_p1.product <= product_p0;
        vld_p2        <= s1_p1.valid;
        data_p2       <= sat_res;
        if (s1_p1.valid && sat_oor) ovf <= 1'b1;
      end
      if (in_valid && adv) count <= count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_real_gain_pipe.sv
// Directed bench for real_gain_pipe: single-sample vector table, streaming with stalls, reset mid-stream, four lanes.
module tb_real_gain_pipe;

  localparam int DW = 16;
  localparam int CW = 16;
  localparam int N  = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic signed [DW-1:0] in_data = '0;

  logic [N-1:0] ir;
  logic [N-1:0] ov;
  logic [N-1:0] of;
  logic signed [DW-1:0] od [N];
  logic [CW-1:0] cnt [N];

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  real_gain_pipe #(.GAIN(2.0)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .ovf(of[0]), .count(cnt[0])
  );

  real_gain_pipe #(.GAIN(-0.5)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .ovf(of[1]), .count(cnt[1])
  );

  for (genvar i = 0; i < 4; i++) begin : g_lane
    localparam real LG = 10.0 * real'(1 + i / 2) + real'(i % 2) + 0.5;
    real_gain_pipe #(.GAIN(LG)) u_l (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[i+2]), .in_data(in_data),
      .out_valid(ov[i+2]), .out_ready(out_ready), .out_data(od[i+2]), .ovf(of[i+2]), .count(cnt[i+2])
    );
  end

  typedef struct {
    int                   sel;
    logic signed [DW-1:0] din;
    logic signed [DW-1:0] exp_out;
    logic                 exp_ovf;
  } vec_t;

  vec_t vt [10];

`ifdef REAL_GAIN_SAT_EN
  localparam logic signed [DW-1:0] EXP_BIG = 16'sd32767;
  localparam logic signed [DW-1:0] EXP_NEG = -16'sd32768;
`else
  localparam logic signed [DW-1:0] EXP_BIG = -16'sd25536;
  localparam logic signed [DW-1:0] EXP_NEG = 16'sd0;
`endif

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    do_reset();
    in_valid = 1'b1;
    in_data = v.din;
    tick();
    in_valid = 1'b0;
    tick();
    chk($sformatf("vec%0d_valid", idx), longint'(ov[v.sel]), 1);
    chk($sformatf("vec%0d_data", idx), longint'(od[v.sel]), longint'(v.exp_out));
    chk($sformatf("vec%0d_ovf", idx), longint'(of[v.sel]), longint'(v.exp_ovf));
    chk($sformatf("vec%0d_count", idx), longint'(cnt[v.sel]), 1);
  endtask

  initial begin
    vt[0] = '{0, 16'sd100, 16'sd200, 1'b0};
    vt[1] = '{0, 16'sd20000, EXP_BIG, 1'b1};
    vt[2] = '{0, -16'sd32768, EXP_NEG, 1'b1};
    vt[3] = '{1, 16'sd7, -16'sd3, 1'b0};
    vt[4] = '{1, -16'sd7, 16'sd4, 1'b0};
    vt[5] = '{1, 16'sd0, 16'sd0, 1'b0};
    vt[6] = '{2, 16'sd4, 16'sd42, 1'b0};
    vt[7] = '{3, 16'sd4, 16'sd46, 1'b0};
    vt[8] = '{4, 16'sd4, 16'sd82, 1'b0};
    vt[9] = '{5, 16'sd4, 16'sd86, 1'b0};

    tick();
    do_reset();
    chk("rst_out_valid", longint'(ov[0]), 0);
    chk("rst_out_data", longint'(od[0]), 0);
    chk("rst_ovf", longint'(of[0]), 0);
    chk("rst_count", longint'(cnt[0]), 0);
    chk("rst_in_ready", longint'(ir[0]), 1);

    for (int k = 0; k < 10; k++) run_vec(vt[k], k);

    // Stream 1..8 with the consumer stalled on cycles 3-5.
    begin
      int sent;
      int rcv;
      int cyc;
      sent = 1;
      rcv = 0;
      cyc = 0;
      do_reset();
      while (rcv < 8 && cyc < 40) begin
        out_ready = !(cyc >= 3 && cyc <= 5);
        in_valid = (sent <= 8);
        in_data = DW'(sent);
        #1;
        if (ov[0] && !out_ready) chk("stall_in_ready", longint'(ir[0]), 0);
        if (ov[0]) begin
          chk($sformatf("stream_data%0d", rcv), longint'(od[0]), longint'(2 * (rcv + 1)));
          if (out_ready) rcv++;
        end
        if (in_valid && ir[0]) sent++;
        tick();
        cyc++;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      chk("stream_rcv", longint'(rcv), 8);
      chk("stream_count", longint'(cnt[0]), 8);
      chk("stream_no_dup", longint'(ov[0]), 0);
    end

    // Reset with two samples in flight, ovf already set.
    do_reset();
    in_valid = 1'b1;
    in_data = 16'sd20000;
    tick();
    in_data = 16'sd3;
    tick();
    in_valid = 1'b0;
    chk("flight_ovf_set", longint'(of[0]), 1);
    chk("flight_valid_set", longint'(ov[0]), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_out_valid", longint'(ov[0]), 0);
    chk("midrst_count", longint'(cnt[0]), 0);
    chk("midrst_ovf", longint'(of[0]), 0);
    chk("midrst_in_ready", longint'(ir[0]), 1);
    tick();
    chk("midrst_discard", longint'(ov[0]), 0);
    in_valid = 1'b1;
    in_data = 16'sd50;
    tick();
    in_valid = 1'b0;
    chk("post_lat1", longint'(ov[0]), 0);
    tick();
    chk("post_valid", longint'(ov[0]), 1);
    chk("post_data", longint'(od[0]), 100);

    // Reset and transfer in the same cycle: reset wins.
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = 16'sd9;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    chk("rst_xfer_count", longint'(cnt[0]), 0);
    tick();
    tick();
    chk("rst_xfer_drop", longint'(ov[0]), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
